// File: rtl/bf16_stream_pkg.sv
// bf16_stream_pkg: shared types and BF16 constants for the stream driver
package bf16_stream_pkg;
    typedef logic [15:0] bf16_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;
    localparam bf16_t ONE  = 16'h3F80;
    localparam bf16_t ZERO = 16'h0000;
    localparam bf16_t QNAN = 16'h7FC0;
endpackage

// File: rtl/bf16_sdp_ram.sv
// bf16_sdp_ram: simple dual-port RAM, one write port and one registered read port
module bf16_sdp_ram #(
    parameter int AW = 6,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or negedge rst)
        if (!rst) rdata <= '0;
        else      rdata <= mem[raddr];
endmodule

// File: rtl/bf16_stream_driver.sv
// bf16_stream_driver: issues buffered BF16 operands to a valid/ready kernel and captures its results
module bf16_stream_driver
    import bf16_stream_pkg::*;
#(
    parameter int AW      = 6,
    parameter int MAX_OUT = 8,
    parameter int W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   num_ops,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [W-1:0]  load_data,
    output logic          op_valid,
    output logic [W-1:0]  op_data,
    input  logic          op_ready,
    input  logic          res_valid,
    input  logic [W-1:0]  res_data,
    output logic          res_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   issued,
    output logic [AW:0]   received,
    output logic [31:0]   cycles
);
    localparam int DEPTH = 1 << AW;
    state_e state, state_n;
    logic [AW:0] num_q, num_clamp, outstanding, issued_n, received_n;
    logic [AW-1:0] op_raddr;
    logic go, fire, take;
    assign go          = start && state == IDLE;
    assign num_clamp   = num_ops > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_ops;
    assign outstanding = issued - received;
    assign op_valid    = state == RUN && issued < num_q && 32'(outstanding) < MAX_OUT;
    assign fire        = op_valid && op_ready;
    assign res_ready   = state == RUN || state == DRAIN;
    assign busy        = res_ready;
    assign take        = res_valid && res_ready;
    assign issued_n    = issued + (AW+1)'(fire);
    assign received_n  = received + (AW+1)'(take);
    // Prefetch the operand that will be current after this edge, so op_data is registered and holds while stalled.
    assign op_raddr    = go ? '0 : issued_n[AW-1:0];
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = num_clamp == '0 ? FIN : RUN;
            RUN:     if (issued_n == num_q) state_n = received_n == num_q ? FIN : DRAIN;
            DRAIN:   if (received_n == num_q) state_n = FIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            num_q    <= '0;
            issued   <= '0;
            received <= '0;
            cycles   <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                num_q    <= num_clamp;
                issued   <= '0;
                received <= '0;
                cycles   <= '0;
                done     <= 1'b0;
            end else begin
                issued   <= issued_n;
                received <= received_n;
                if (state != IDLE && cycles != '1) cycles <= cycles + 32'd1;
                if (state == FIN) done <= 1'b1;
            end
        end
    end
    bf16_sdp_ram #(.AW(AW), .W(W)) u_op_buf (
        .clk(clk), .rst(rst), .we(load_en), .waddr(load_addr), .wdata(load_data),
        .raddr(op_raddr), .rdata(op_data)
    );
    bf16_sdp_ram #(.AW(AW), .W(W)) u_res_buf (
        .clk(clk), .rst(rst), .we(take), .waddr(received[AW-1:0]), .wdata(res_data),
        .raddr(rd_addr), .rdata(rd_data)
    );
endmodule

// File: tb/tb_bf16_stream_driver.sv
// tb_bf16_stream_driver: echo-kernel model with scoreboard around bf16_stream_driver
module tb_bf16_stream_driver;
    localparam int AW = 6;
    localparam int MAXO = 8;
    logic clk = 0, rst = 0, start = 0, load_en = 0, op_ready = 0, res_valid = 0;
    logic [AW:0] num_ops = '0;
    logic [AW-1:0] load_addr = '0, rd_addr = '0;
    logic [15:0] load_data = '0, res_data = '0;
    logic op_valid, res_ready, busy, done;
    logic [15:0] op_data, rd_data;
    logic [AW:0] issued, received;
    logic [31:0] cycles;
    bf16_stream_driver #(.AW(AW), .MAX_OUT(MAXO), .W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_ops(num_ops),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .issued(issued), .received(received), .cycles(cycles)
    );
    always #5 clk = ~clk;
    typedef struct {logic [15:0] d; int t;} ent_t;
    ent_t kq[$];
    logic [15:0] sb[$];
    logic [15:0] opm [64];
    int n_chk = 0, n_err = 0;
    int cyc = 0, lat = 3, stall_until = 0, rdy_mode = 0, n_fire = 0, n_take = 0;
    logic hold_pend = 0;
    logic [15:0] hold_d = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        ent_t e;
        @(negedge clk);
        cyc++;
        start = 0;
        load_en = 0;
        if (hold_pend) begin
            check("hold_valid", 32'(op_valid), 32'd1);
            check("hold_data", 32'(op_data), 32'(hold_d));
        end
        op_ready  = rdy_mode == 0 || cyc % 2 == 1;
        res_valid = kq.size() > 0 && kq[0].t <= cyc && cyc >= stall_until;
        res_data  = res_valid ? kq[0].d : 16'h0;
        if (op_valid) check("credit", 32'(n_fire - n_take < MAXO), 32'd1);
        hold_pend = op_valid && !op_ready;
        hold_d    = op_data;
        if (op_valid && op_ready) begin
            check("op_data", 32'(op_data), 32'(opm[n_fire % 64]));
            e.d = op_data;
            e.t = cyc + lat;
            kq.push_back(e);
            sb.push_back(opm[n_fire % 64]);
            n_fire++;
        end
        if (res_valid && res_ready) begin
            void'(kq.pop_front());
            n_take++;
        end
    endtask
    task automatic load(input int a, input logic [15:0] d);
        load_en = 1;
        load_addr = AW'(a);
        load_data = d;
        opm[a] = d;
        step();
    endtask
    task automatic run_start(input int n);
        n_fire = 0;
        n_take = 0;
        hold_pend = 0;
        sb.delete();
        kq.delete();
        start = 1;
        num_ops = (AW+1)'(n);
        step();
    endtask
    task automatic run_finish(input string tag, input int n);
        for (int i = 0; i < 3000 && !done; i++) step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fires"}, 32'(n_fire), 32'(n));
        check({tag, "_issued"}, 32'(issued), 32'(n));
        check({tag, "_received"}, 32'(received), 32'(n));
        check({tag, "_sb_count"}, 32'(sb.size()), 32'(n));
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            rd_addr = AW'(i);
            step();
            check({tag, "_result"}, 32'(rd_data), 32'(sb.pop_front()));
        end
    endtask
    initial begin
        repeat (5) step();
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_counts", 32'({issued, received}), 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1;
        step();
        // zero-length run goes straight to done
        run_start(0);
        step();
        check("zero_done", 32'(done), 32'd1);
        check("zero_issued", 32'(issued), 32'd0);
        check("zero_received", 32'(received), 32'd0);
        // single op through a 3-cycle echo kernel
        load(0, 16'h3F80);
        lat = 3;
        run_start(1);
        run_finish("single", 1);
        check("single_cycles", cycles, 32'd5);
        // 64-op stream, credit limit checked every cycle in step
        for (int i = 0; i < 64; i++) load(i, 16'h3F80 + 16'(i));
        lat = 4;
        run_start(64);
        run_finish("stream", 64);
        // oversize num_ops clamps to buffer depth
        lat = 2;
        run_start(100);
        run_finish("clamp", 64);
        // backpressure: ready toggles, data must hold while stalled
        rdy_mode = 1;
        run_start(10);
        run_finish("bp", 10);
        rdy_mode = 0;
        // credit stall: results withheld for 20 cycles
        lat = 1;
        stall_until = cyc + 20;
        run_start(16);
        repeat (14) step();
        check("stall_fires", 32'(n_fire), 32'd8);
        check("stall_issued", 32'(issued), 32'd8);
        check("stall_op_valid", 32'(op_valid), 32'd0);
        run_finish("stall", 16);
        stall_until = 0;
        // async reset mid-run
        rdy_mode = 1;
        lat = 3;
        run_start(16);
        for (int i = 0; i < 200 && n_fire < 5; i++) step();
        #2 rst = 0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_op_valid", 32'(op_valid), 32'd0);
        check("arst_res_ready", 32'(res_ready), 32'd0);
        check("arst_issued", 32'(issued), 32'd0);
        kq.delete();
        sb.delete();
        hold_pend = 0;
        n_fire = 0;
        n_take = 0;
        step();
        step();
        rst = 1;
        step();
        run_start(16);
        run_finish("after_rst", 16);
        rdy_mode = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
